// File: rtl/fp_add_responder_if.sv
// Request/response bundle for the fp_add_responder: operands and start strobe
// from the initiator, registered sum, ready pulse and busy back from the block.
interface fp_add_responder_if #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
);
    localparam int W = EXP_LEN + MANTISSA_LEN + 1;

    logic         add_start;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_sum;
    logic         add_ready;
    logic         busy;

    modport master (
        output add_start, add_a, add_b,
        input  add_sum, add_ready, busy
    );

    modport slave (
        input  add_start, add_a, add_b,
        output add_sum, add_ready, busy
    );
endinterface

// File: rtl/fp_add_responder.sv
// Multi-cycle floating-point adder: one stage per state (ALIGN/ADD/NORM/ROUND/DONE),
// flush-to-zero on denormals, round-to-nearest-even, canonical quiet NaN.
module fp_add_responder #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
) (
    input  logic              clock,
    input  logic              reset_n,
    fp_add_responder_if.slave bus
);
    localparam int W  = EXP_LEN + MANTISSA_LEN + 1;
    localparam int MW = MANTISSA_LEN + 4;   // hidden + fraction + guard/round/sticky
    localparam int EW = EXP_LEN + 2;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};
    localparam logic signed [EW-1:0] EXP_MAX = {2'b00, {EXP_LEN{1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         a_q, b_q;
    logic                 l_sign_q, l_sign_d, sub_q, sub_d;
    logic [EXP_LEN-1:0]   l_exp_q, l_exp_d;
    logic [MW-1:0]        l_mant_q, l_mant_d, s_mant_q, s_mant_d;
    logic                 special_q, special_d, zero_sign_q, zero_sign_d;
    logic [W-1:0]         special_val_q, special_val_d;
    logic [MW:0]          sum_q, sum_d;
    logic [MW-1:0]        norm_mant_q, norm_mant_d;
    logic signed [EW-1:0] norm_exp_q, norm_exp_d;
    logic                 norm_zero_q, norm_zero_d;
    logic [W-1:0]         res_q, res_d, add_sum_q;
    logic                 add_ready_q;

    // Operand classification
    logic [EXP_LEN-1:0] ea, eb, s_exp, diff;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
    logic [W-2:0]       a_mag, b_mag;
    logic [MW-1:0]      a_mant, b_mant, s_raw;
    logic [31:0]        shamt;
    logic [2*MW-1:0]    wide;

    assign ea     = a_q[W-2 -: EXP_LEN];
    assign eb     = b_q[W-2 -: EXP_LEN];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (a_q[MANTISSA_LEN-1:0] == '0);
    assign b_inf  = (eb == '1) && (b_q[MANTISSA_LEN-1:0] == '0);
    assign a_nan  = (ea == '1) && (a_q[MANTISSA_LEN-1:0] != '0);
    assign b_nan  = (eb == '1) && (b_q[MANTISSA_LEN-1:0] != '0);
    assign a_mag  = a_zero ? '0 : a_q[W-2:0];
    assign b_mag  = b_zero ? '0 : b_q[W-2:0];
    assign a_mant = a_zero ? '0 : {1'b1, a_q[MANTISSA_LEN-1:0], 3'b000};
    assign b_mant = b_zero ? '0 : {1'b1, b_q[MANTISSA_LEN-1:0], 3'b000};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.add_start) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_big    = (a_mag >= b_mag);
        l_sign_d = a_big ? a_q[W-1] : b_q[W-1];
        l_exp_d  = a_big ? ea : eb;
        s_exp    = a_big ? eb : ea;
        l_mant_d = a_big ? a_mant : b_mant;
        s_raw    = a_big ? b_mant : a_mant;
        sub_d    = a_q[W-1] ^ b_q[W-1];
        diff     = l_exp_d - s_exp;
        // Shifts past the guard position collapse the whole operand into sticky.
        shamt    = (32'(diff) > 32'(MW-1)) ? 32'(MW-1) : 32'(diff);
        wide     = {s_raw, {MW{1'b0}}} >> shamt;
        s_mant_d = wide[2*MW-1:MW] | {{(MW-1){1'b0}}, |wide[MW-1:0]};
        zero_sign_d   = a_zero & b_zero & a_q[W-1] & b_q[W-1];
        special_d     = a_nan | b_nan | a_inf | b_inf;
        special_val_d = (a_nan | b_nan | (a_inf & b_inf & sub_d)) ? QNAN :
                        a_inf ? a_q : b_q;
    end

    assign sum_d = sub_q ? ({1'b0, l_mant_q} - {1'b0, s_mant_q})
                         : ({1'b0, l_mant_q} + {1'b0, s_mant_q});

    logic [EW-1:0] lzc;
    logic          found;

    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found) begin
                if (sum_q[i]) found = 1'b1;
                else          lzc   = lzc + EW'(1);
            end
        end
        norm_zero_d = (sum_q == '0);
        if (sum_q[MW]) begin
            norm_mant_d = {sum_q[MW:2], sum_q[1] | sum_q[0]};
            norm_exp_d  = {2'b00, l_exp_q} + EW'(1);
        end else begin
            norm_mant_d = sum_q[MW-1:0] << lzc;
            norm_exp_d  = {2'b00, l_exp_q} - lzc;
        end
    end

    logic                    round_up;
    logic [MW-3:0]           rounded;
    logic [MANTISSA_LEN-1:0] frac;
    logic signed [EW-1:0]    r_exp;

    always_comb begin
        round_up = norm_mant_q[2] & (norm_mant_q[1] | norm_mant_q[0] | norm_mant_q[3]);
        rounded  = {1'b0, norm_mant_q[MW-1:3]} + {{(MW-3){1'b0}}, round_up};
        frac     = rounded[MW-3] ? rounded[MANTISSA_LEN:1] : rounded[MANTISSA_LEN-1:0];
        r_exp    = norm_exp_q + {{(EW-1){1'b0}}, rounded[MW-3]};
        if (special_q)
            res_d = special_val_q;
        else if (norm_zero_q)
            res_d = {zero_sign_q, {(W-1){1'b0}}};
        else if (norm_exp_q[EW-1] || norm_exp_q == '0)
            res_d = {l_sign_q, {(W-1){1'b0}}};
        else if (r_exp >= EXP_MAX)
            res_d = {l_sign_q, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
        else
            res_d = {l_sign_q, r_exp[EXP_LEN-1:0], frac};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q           <= '0;
            b_q           <= '0;
            l_sign_q      <= 1'b0;
            sub_q         <= 1'b0;
            l_exp_q       <= '0;
            l_mant_q      <= '0;
            s_mant_q      <= '0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            zero_sign_q   <= 1'b0;
            sum_q         <= '0;
            norm_mant_q   <= '0;
            norm_exp_q    <= '0;
            norm_zero_q   <= 1'b0;
            res_q         <= '0;
            add_sum_q     <= '0;
            add_ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.add_start) begin
                    a_q <= bus.add_a;
                    b_q <= bus.add_b;
                end
                S_ALIGN: begin
                    l_sign_q      <= l_sign_d;
                    sub_q         <= sub_d;
                    l_exp_q       <= l_exp_d;
                    l_mant_q      <= l_mant_d;
                    s_mant_q      <= s_mant_d;
                    special_q     <= special_d;
                    special_val_q <= special_val_d;
                    zero_sign_q   <= zero_sign_d;
                end
                S_ADD:   sum_q <= sum_d;
                S_NORM: begin
                    norm_mant_q <= norm_mant_d;
                    norm_exp_q  <= norm_exp_d;
                    norm_zero_q <= norm_zero_d;
                end
                S_ROUND: res_q <= res_d;
                default: ;
            endcase
            add_ready_q <= (state_q == S_DONE);
            if (state_q == S_DONE) add_sum_q <= res_q;
        end
    end

    assign bus.add_sum   = add_sum_q;
    assign bus.add_ready = add_ready_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_fp_add_responder.sv
// Bench for fp_add_responder: exact-arithmetic reference model with a per-cycle
// compare process, plus directed vectors with literal expected sums.
module tb_fp_add_responder;
    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    fp_add_responder_if #(.EXP_LEN(8), .MANTISSA_LEN(23)) bus ();
    fp_add_responder #(.EXP_LEN(8), .MANTISSA_LEN(23)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact value of a normal float, scaled by 2^149, is mant * 2^(exp-1).
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        logic         sa, sb, sr;
        int           ea, eb, p, er, sh;
        logic [319:0] ma, mb, mag, m, rem, half;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
            (ea == 255 && eb == 255 && sa != sb))
            return 32'h7FC00000;
        if (ea == 255) return a;
        if (eb == 255) return b;
        if (ea == 0 && eb == 0) return {sa & sb, 31'b0};
        ma = (ea == 0) ? '0 : (320'({1'b1, a[22:0]}) << (ea - 1));
        mb = (eb == 0) ? '0 : (320'({1'b1, b[22:0]}) << (eb - 1));
        if (sa == sb)      begin mag = ma + mb; sr = sa; end
        else if (ma >= mb) begin mag = ma - mb; sr = sa; end
        else               begin mag = mb - ma; sr = sb; end
        if (mag == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 320; i++) if (mag[i]) p = i;
        er = p - 22;
        if (er <= 0) return {sr, 31'b0};
        sh   = p - 23;
        m    = mag >> sh;
        rem  = mag & ((320'd1 << sh) - 320'd1);
        half = (sh > 0) ? (320'd1 << (sh - 1)) : '0;
        if (sh > 0 && (rem > half || (rem == half && m[0]))) m = m + 320'd1;
        if (m[24]) begin m = m >> 1; er++; end
        if (er >= 255) return {sr, 8'hFF, 23'b0};
        return {sr, er[7:0], m[22:0]};
    endfunction

    // Timing model: accepted request surfaces five edges later as a one-cycle pulse.
    int          phase_m = 0;
    logic [31:0] pend_m  = '0;
    logic [31:0] sum_m   = '0;
    logic        ready_m = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_m <= 0;
            pend_m  <= '0;
            sum_m   <= '0;
            ready_m <= 1'b0;
        end else begin
            ready_m <= 1'b0;
            if (phase_m == 5) begin
                sum_m   <= pend_m;
                ready_m <= 1'b1;
                phase_m <= 0;
            end else if (phase_m != 0) begin
                phase_m <= phase_m + 1;
            end else if (bus.add_start) begin
                pend_m  <= model_add(bus.add_a, bus.add_b);
                phase_m <= 1;
            end
        end
    end

    always @(negedge clock) begin
        check("cmp_ready", 32'(bus.add_ready), 32'(ready_m));
        check("cmp_busy",  32'(bus.busy),      32'(phase_m != 0));
        check("cmp_sum",   bus.add_sum,        sum_m);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        string       name;
    } vec_t;

    vec_t vecs[17] = '{
        '{32'h3F800000, 32'h40000000, 32'h40400000, "one_plus_two"},
        '{32'h40C90FDB, 32'hC0C90FDB, 32'h00000000, "cancel_pos_zero"},
        '{32'h80000000, 32'h80000000, 32'h80000000, "negzero_negzero"},
        '{32'h00000000, 32'h80000000, 32'h00000000, "poszero_negzero"},
        '{32'h00000001, 32'h3F800000, 32'h3F800000, "ftz_denorm_in"},
        '{32'h3F800000, 32'h33800000, 32'h3F800000, "tie_even_down"},
        '{32'h3F800000, 32'h33800001, 32'h3F800001, "above_half_up"},
        '{32'h3F800001, 32'h33800000, 32'h3F800002, "tie_odd_up"},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow_inf"},
        '{32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf"},
        '{32'hFF800000, 32'h3F800000, 32'hFF800000, "neginf_finite"},
        '{32'h7FC00001, 32'h00000000, 32'h7FC00000, "nan_canon"},
        '{32'h7F800000, 32'h7F800000, 32'h7F800000, "inf_plus_inf"},
        '{32'h3F800000, 32'hBF7FFFFF, 32'h33800000, "deep_cancel"},
        '{32'h40000000, 32'hBF800000, 32'h3F800000, "two_minus_one"},
        '{32'h00800000, 32'h00800000, 32'h01000000, "min_normal_x2"},
        '{32'h00800000, 32'h80800001, 32'h80000000, "underflow_neg"}
    };

    logic [31:0] hold_a[3] = '{32'h3F800000, 32'h40000000, 32'h3F800000};
    logic [31:0] hold_b[3] = '{32'h40000000, 32'h40000000, 32'hBF800000};
    logic [31:0] hold_s[3] = '{32'h40400000, 32'h40800000, 32'h00000000};

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s, input string name);
        int lat;
        bus.add_start = 1'b1;
        bus.add_a     = a;
        bus.add_b     = b;
        @(negedge clock);
        bus.add_start = 1'b0;
        bus.add_a     = $urandom;
        bus.add_b     = $urandom;
        check({name, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 1;
        while (!bus.add_ready && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        check({name, "_lat"}, lat, 6);
        check(name, bus.add_sum, s);
        check({name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int seen;
        bus.add_start = 1'b0;
        bus.add_a     = '0;
        bus.add_b     = '0;
        reset_n       = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_sum",   bus.add_sum,          32'h0);
        check("rst_ready", 32'(bus.add_ready),   32'd0);
        check("rst_busy",  32'(bus.busy),        32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].name);

        // Model-only traffic: operands with nearby exponents to exercise alignment and rounding.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = {1'($urandom), 8'(a[30:23] + 8'($urandom_range(0, 30)) - 8'd15), 23'($urandom)};
            bus.add_start = 1'b1;
            bus.add_a     = a;
            bus.add_b     = b;
            @(negedge clock);
            bus.add_start = 1'b0;
            repeat (5) @(negedge clock);
        end

        // Reset during NORM: three negedges after driving the request.
        bus.add_start = 1'b1;
        bus.add_a     = 32'h3F800000;
        bus.add_b     = 32'h40000000;
        @(negedge clock);
        bus.add_start = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("abort_sum",   bus.add_sum,        32'h0);
        check("abort_ready", 32'(bus.add_ready), 32'd0);
        check("abort_busy",  32'(bus.busy),      32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (bus.add_ready) seen++;
        end
        check("abort_no_ready", seen, 0);
        do_op(32'h3F800000, 32'hBF800000, 32'h00000000, "after_abort");

        // add_start held high: accepts every sixth edge, operands churn in between.
        for (int i = 0; i <= 18; i++) begin
            if (i > 0) begin
                @(negedge clock);
                if (i % 6 == 0) begin
                    check($sformatf("hold_ready_%0d", i), 32'(bus.add_ready), 32'd1);
                    check($sformatf("hold_sum_%0d", i), bus.add_sum, hold_s[i/6 - 1]);
                end else begin
                    check($sformatf("hold_idle_%0d", i), 32'(bus.add_ready), 32'd0);
                end
            end
            bus.add_start = (i <= 12);
            if (i % 6 == 0 && i <= 12) begin
                bus.add_a = hold_a[i/6];
                bus.add_b = hold_b[i/6];
            end else begin
                bus.add_a = $urandom;
                bus.add_b = $urandom;
            end
        end
        bus.add_start = 1'b0;
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_add_responder.md
FP_ADD_RESPONDER -- requirements
Module: fp_add_responder

Interface
REQ-001 SHALL have parameter EXP_LEN, default 8, exponent field width.
REQ-002 SHALL have parameter MANTISSA_LEN, default 23, stored fraction width; word width W = EXP_LEN+MANTISSA_LEN+1.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clock  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 add_start  input  1  request strobe from initiator; sampled only in IDLE.
REQ-007 add_a  input  W  operand A, {sign, exp, fraction}, sampled with add_start.
REQ-008 add_b  input  W  operand B, same format, sampled with add_start.
REQ-009 add_sum  output  W  registered result A+B; held until next result.
REQ-010 add_ready  output  1  one-cycle pulse, add_sum valid while high.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, ALIGN, ADD, NORM, ROUND, DONE, stepping exactly one state per clock.
REQ-013 IDLE with add_start=1 at edge E: latch add_a/add_b, go ALIGN; add_start in any other state SHALL be ignored (no queuing).
REQ-014 Transitions ALIGN->ADD->NORM->ROUND->DONE->IDLE unconditional; add_sum updated and add_ready=1 at edge E+5; add_ready=0 at edge E+6.
REQ-015 Next earliest accept SHALL be edge E+6 (throughput one op per 6 cycles); add_start high at E+5 SHALL be ignored.
REQ-016 UNPACK/ALIGN: hidden bit = 1 for nonzero exp; exp==0 operands SHALL be treated as signed zero (flush-to-zero); smaller-magnitude operand right-shifted by exponent difference with guard, round and sticky bits; shift >= MANTISSA_LEN+3 yields sticky only.
REQ-017 ADD: same signs add magnitudes; differing signs subtract smaller from larger, result takes sign of larger-magnitude operand.
REQ-018 NORM: carry-out SHALL shift right one (sticky preserved) and increment exponent; otherwise left-shift by leading-zero count and decrement exponent.
REQ-019 ROUND: round-to-nearest-even on guard/round/sticky; mantissa overflow after rounding SHALL renormalize and increment exponent.
REQ-020 Result exponent <= 0 after normalization SHALL flush to signed zero with result sign.
REQ-021 Result exponent >= all-ones SHALL produce infinity of result sign.
REQ-022 Exact zero from cancellation SHALL be +0; (-0)+(-0) SHALL be -0; (+0)+(-0) SHALL be +0.
REQ-023 Either operand NaN, or +inf plus -inf, SHALL produce canonical quiet NaN: sign 0, exp all ones, fraction MSB 1, rest 0.
REQ-024 inf plus finite, or inf plus same-sign inf, SHALL produce that infinity.
REQ-025 Latency SHALL be identical (5 edges) for all operand classes, including specials and zeros.
REQ-026 Block SHALL only add; subtraction is the initiator's sign flip of add_b.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, add_sum=0, add_ready=0, busy=0, operand registers 0, independent of clock.
REQ-028 Reset mid-operation SHALL abort the operation with no add_ready pulse; first accept possible at first rising edge with reset_n high.

Verification
REQ-029 3F800000 + 40000000 accepted at edge E -> add_sum=40400000, add_ready high exactly cycle after E+5, busy high E+1..E+5.
REQ-030 40C90FDB + C0C90FDB -> 00000000; 80000000 + 80000000 -> 80000000; 00000001 + 3F800000 -> 3F800000 (FTZ).
REQ-031 3F800000 + 33800000 -> 3F800000 (tie to even); 3F800000 + 33800001 -> 3F800001; 3F800001 + 33800000 -> 3F800002.
REQ-032 7F7FFFFF + 7F7FFFFF -> 7F800000; 7F800000 + FF800000 -> 7FC00000; FF800000 + 3F800000 -> FF800000; 7FC00001 + 0 -> 7FC00000.
REQ-033 reset_n pulsed low during NORM -> no add_ready, add_sum=00000000, busy=0; following 3F800000 + BF800000 -> 00000000 at 5-edge latency.
REQ-034 add_start held high continuously -> accepts at E, E+6, E+12; add_ready pulses at E+5, E+11; mid-op operand changes do not affect results.
